// File: rtl/scan_capture.sv
// scan_capture: drives an external register scanner through one parallel
// load followed by N serial shifts, collecting the scanned bits LSB-first
// into a WORDS x 16-bit capture buffer that the host reads back.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   start     in   single-cycle capture request (honoured only when idle)
//   num_bits  in   [7:0] bits to capture, latched on the accepted start
//   busy      out  capture in progress
//   done      out  one-cycle completion pulse
//   rd_addr   in   [AW-1:0] buffer word index for host reads
//   rd_data   out  [15:0] registered buffer word at rd_addr (1-cycle latency)
//   scan_clk  out  generated scan-path clock
//   scan_en   out  0 = parallel load, 1 = shift
//   scan_in   in   serial data from the scanner's scan_out
module scan_capture #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned WORDS   = 8,
  localparam int unsigned AW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    num_bits,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic          scan_clk,
  output logic          scan_en,
  input  logic          scan_in
);

  localparam int unsigned CAP = WORDS * 16;
  localparam int unsigned CW  = $clog2(CAP + 1);
  localparam int unsigned DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    SHIFT_LO,
    SHIFT_HI,
    FINISH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_cnt;
  logic [DW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   r_idx;
  logic [CW-1:0]   r_n;
  logic [CW-1:0]   w_n;
  logic            w_tick;
  logic            w_accept;
  logic            w_wr;
  logic [15:0]     r_buf [WORDS];
  logic [15:0]     r_rd_data;
  logic            r_busy;
  logic            r_done;
  logic            r_scan_clk;
  logic            r_scan_en;

  // Requested length clamped to the buffer capacity.
  always_comb begin
    if (32'(num_bits) > CAP) w_n = CW'(CAP);
    else                     w_n = CW'(num_bits);
  end

  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - DW'(1) : r_cnt;
    w_accept    = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_n == '0) begin
            w_state_nxt = FINISH;
          end else begin
            w_state_nxt = LOAD_LO;
            w_cnt_nxt   = RELOAD;
          end
        end
      end
      LOAD_LO: begin
        if (w_tick) begin
          w_state_nxt = LOAD_HI;
          w_cnt_nxt   = RELOAD;
        end
      end
      LOAD_HI: begin
        if (w_tick) begin
          w_state_nxt = SHIFT_LO;
          w_cnt_nxt   = RELOAD;
        end
      end
      SHIFT_LO: begin
        // Sample on the last low cycle, just before the shift pulse.
        if (w_tick) begin
          w_wr        = 1'b1;
          w_state_nxt = SHIFT_HI;
          w_cnt_nxt   = RELOAD;
        end
      end
      SHIFT_HI: begin
        // r_idx already counts the bit sampled in the preceding SHIFT_LO.
        if (w_tick) begin
          w_cnt_nxt   = RELOAD;
          w_state_nxt = (r_idx < r_n) ? SHIFT_LO : FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_n        <= '0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_scan_clk <= 1'b0;
      r_scan_en  <= 1'b0;
      for (int unsigned i = 0; i < WORDS; i++) r_buf[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      // Outputs follow the next state so they stay aligned with r_state.
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == FINISH);
      r_scan_clk <= (w_state_nxt == LOAD_HI) || (w_state_nxt == SHIFT_HI);
      r_scan_en  <= (w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI);
      // Read samples the array before this edge's write: old data on collision.
      r_rd_data  <= r_buf[rd_addr];
      if (w_accept) begin
        r_n   <= w_n;
        r_idx <= '0;
        if (w_n != '0) begin
          for (int unsigned i = 0; i < WORDS; i++) r_buf[i] <= '0;
        end
      end
      if (w_wr) begin
        r_buf[r_idx[AW+3:4]][r_idx[3:0]] <= scan_in;
        r_idx <= r_idx + CW'(1);
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_data  = r_rd_data;
  assign scan_clk = r_scan_clk;
  assign scan_en  = r_scan_en;

endmodule

// File: tb/tb_scan_capture.sv
// Directed bench for scan_capture: one instance with CLK_DIV=1 for the
// functional scenarios and one with CLK_DIV=4 for phase timing. Each has a
// behavioural scanner: parallel load on a scan_clk rise with scan_en=0,
// LSB-out shift on a rise with scan_en=1.
module tb_scan_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, start4;
  logic [7:0]  nb1, nb4;
  logic        busy1, busy4, done1, done4;
  logic [2:0]  ra1, ra4;
  logic [15:0] rd1, rd4;
  logic        sclk1, sclk4, sen1, sen4, sin1, sin4;

  scan_capture #(.CLK_DIV(1), .WORDS(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .num_bits(nb1),
    .busy(busy1), .done(done1), .rd_addr(ra1), .rd_data(rd1),
    .scan_clk(sclk1), .scan_en(sen1), .scan_in(sin1)
  );

  scan_capture #(.CLK_DIV(4), .WORDS(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .num_bits(nb4),
    .busy(busy4), .done(done4), .rd_addr(ra4), .rd_data(rd4),
    .scan_clk(sclk4), .scan_en(sen4), .scan_in(sin4)
  );

  // Scanner models
  logic [255:0] sc1 = '0, ld1 = '0, sc4 = '0, ld4 = '0;
  int lp1 = 0, sp1 = 0, lp4 = 0, sp4 = 0;
  always @(posedge sclk1) begin
    if (!sen1) begin sc1 <= ld1; lp1++; end
    else       begin sc1 <= {1'b0, sc1[255:1]}; sp1++; end
  end
  always @(posedge sclk4) begin
    if (!sen4) begin sc4 <= ld4; lp4++; end
    else       begin sc4 <= {1'b0, sc4[255:1]}; sp4++; end
  end
  assign sin1 = sc1[0];
  assign sin4 = sc4[0];

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Phase-length and scan_en stability monitor on the CLK_DIV=4 instance.
  logic p_sclk = 1'b0, p_sen = 1'b0, p_busy = 1'b0;
  int   run = 0;
  always @(negedge clk) begin
    if (busy4) begin
      if (p_busy && sclk4 == p_sclk) run++;
      else begin
        if (p_busy) check("phase_len", run, 4);
        run = 1;
      end
      if (p_busy && sclk4 && !p_sclk) check("sen_stable", {31'b0, sen4}, {31'b0, p_sen});
    end
    p_sclk = sclk4;
    p_sen  = sen4;
    p_busy = busy4;
  end

  // Start a capture; lat = cycle index (1 = first cycle after accept) of done.
  task automatic capture(input bit d4, input logic [7:0] n, output int lat);
    int c;
    @(negedge clk);
    if (d4) begin nb4 = n; start4 = 1'b1; end
    else    begin nb1 = n; start1 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    c = 1;
    while (!(d4 ? done4 : done1) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    lat = (d4 ? done4 : done1) ? c : -1;
  endtask

  task automatic rd_word(input bit d4, input int a, output logic [15:0] d);
    @(negedge clk);
    if (d4) ra4 = 3'(a); else ra1 = 3'(a);
    @(negedge clk);
    d = d4 ? rd4 : rd1;
  endtask

  initial begin
    int lat, bl, bs, dones, maxbusy;
    bit inj;
    logic [15:0] w;
    logic [15:0] exp4 [8];

    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; nb1 = '0; nb4 = '0; ra1 = '0; ra4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy1}, 0);
    check("rst_done", {31'b0, done1}, 0);
    check("rst_sclk", {31'b0, sclk1}, 0);
    check("rst_sen",  {31'b0, sen1}, 0);
    check("rst_rd",   {16'b0, rd1}, 0);
    check("rst_busy4", {31'b0, busy4}, 0);
    reset = 1'b0;

    // 16 bits of 16'hA5C3
    ld1 = 256'hA5C3; bl = lp1; bs = sp1;
    capture(0, 8'd16, lat);
    check("n16_lat", lat, 35);
    check("n16_loads", lp1 - bl, 1);
    check("n16_shifts", sp1 - bs, 16);
    rd_word(0, 0, w); check("n16_w0", {16'b0, w}, 32'hA5C3);
    rd_word(0, 1, w); check("n16_w1", {16'b0, w}, 0);

    // 20 bits: 16'h1234 then 4'hB
    ld1 = 256'hB1234; bs = sp1;
    capture(0, 8'd20, lat);
    check("n20_lat", lat, 43);
    check("n20_shifts", sp1 - bs, 20);
    for (int i = 0; i < 8; i++) begin
      rd_word(0, i, w);
      check($sformatf("n20_w%0d", i), {16'b0, w}, (i == 0) ? 32'h1234 : (i == 1) ? 32'h000B : 32'h0);
    end

    // N = 0: immediate done, no scan activity, buffer retained
    ld1 = 256'hFFFF; bl = lp1; bs = sp1;
    capture(0, 8'd0, lat);
    check("n0_lat", lat, 1);
    check("n0_loads", lp1 - bl, 0);
    check("n0_shifts", sp1 - bs, 0);
    rd_word(0, 0, w); check("n0_w0", {16'b0, w}, 32'h1234);
    rd_word(0, 1, w); check("n0_w1", {16'b0, w}, 32'h000B);

    // 200 requested, clamped to 128
    ld1 = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0123456789ABCDEF_FEDCBA9876543210};
    exp4 = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    bs = sp1;
    capture(0, 8'd200, lat);
    check("n200_lat", lat, 259);
    check("n200_shifts", sp1 - bs, 128);
    for (int i = 0; i < 8; i++) begin
      rd_word(0, i, w);
      check($sformatf("n200_w%0d", i), {16'b0, w}, {16'b0, exp4[i]});
    end

    // CLK_DIV=4 instance: 3 bits of 3'b101
    ld4 = 256'h5; bl = lp4; bs = sp4;
    capture(1, 8'd3, lat);
    check("d4_lat", lat, 33);
    check("d4_loads", lp4 - bl, 1);
    check("d4_shifts", sp4 - bs, 3);
    rd_word(1, 0, w); check("d4_w0", {16'b0, w}, 32'h0005);

    // Second start during shift 5 is ignored
    ld1 = 256'h5A0F; bs = sp1; dones = 0; inj = 0;
    @(negedge clk); nb1 = 8'd16; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (done1) dones++;
      if (sp1 - bs == 5 && !inj) begin start1 = 1'b1; nb1 = 8'd3; inj = 1; end
      else start1 = 1'b0;
      @(negedge clk);
    end
    check("restart_injected", {31'b0, inj}, 1);
    check("restart_dones", dones, 1);
    check("restart_shifts", sp1 - bs, 16);
    rd_word(0, 0, w); check("restart_w0", {16'b0, w}, 32'h5A0F);

    // Reset at shift 5 (with start held alongside reset)
    ld1 = 256'hFFFF; bs = sp1; inj = 0;
    @(negedge clk); nb1 = 8'd16; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 80 && !inj; c++) begin
      if (sp1 - bs == 5) inj = 1;
      else @(negedge clk);
    end
    check("rst5_reached", {31'b0, inj}, 1);
    reset = 1'b1; start1 = 1'b1;
    @(negedge clk);
    check("rst5_sclk", {31'b0, sclk1}, 0);
    check("rst5_sen",  {31'b0, sen1}, 0);
    check("rst5_busy", {31'b0, busy1}, 0);
    check("rst5_done", {31'b0, done1}, 0);
    check("rst5_rd",   {16'b0, rd1}, 0);
    reset = 1'b0; start1 = 1'b0;
    dones = 0; maxbusy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) dones++;
      if (busy1) maxbusy = 1;
    end
    check("rst5_no_done", dones, 0);
    check("rst5_idle", maxbusy, 0);
    for (int i = 0; i < 8; i++) begin
      rd_word(0, i, w);
      check($sformatf("rst5_w%0d", i), {16'b0, w}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per scan_clk half-period (>=1).
REQ-002 Parameter WORDS, default 8: capture buffer depth in 16-bit words (power of 2); AW = log2(WORDS).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a capture.
REQ-006 num_bits  input  8  number of scan bits to capture; sampled on the accepted start.
REQ-007 busy  output  1  capture in progress.
REQ-008 done  output  1  one-cycle pulse at capture completion.
REQ-009 rd_addr  input  AW  buffer word index for host read.
REQ-010 rd_data  output  16  buffer word at rd_addr, registered.
REQ-011 scan_clk  output  1  generated scan-path clock to the register scanner.
REQ-012 scan_en  output  1  0 = parallel load, 1 = shift.
REQ-013 scan_in  input  1  serial data from the scanner's scan_out.

Function
REQ-014 FSM states IDLE, LOAD_LO, LOAD_HI, SHIFT_LO, SHIFT_HI, FINISH; all outputs registered.
REQ-015 Each LOAD_LO/LOAD_HI/SHIFT_LO/SHIFT_HI state lasts exactly CLK_DIV clk cycles, timed by a down-counter.
REQ-016 scan_clk = 1 only in LOAD_HI and SHIFT_HI; scan_en = 1 only in SHIFT_LO and SHIFT_HI.
REQ-017 start accepted only in IDLE; start while busy ignored, no effect on the latched count or buffer.
REQ-018 On accepted start: count N = min(num_bits, WORDS*16) latched; bit index cleared; all buffer words cleared to 16'h0000 (only if N>0).
REQ-019 N = 0: IDLE -> FINISH next cycle; no scan_clk/scan_en activity; buffer unchanged.
REQ-020 N > 0: IDLE -> LOAD_LO -> LOAD_HI -> SHIFT_LO; the LOAD_HI pulse makes the scanner capture its parallel value.
REQ-021 On the last clk cycle of each SHIFT_LO, scan_in is written to buffer bit (index mod 16) of word (index div 16); index then increments.
REQ-022 Bit order LSB-first: first sampled bit -> word 0 bit 0; bit 16 -> word 1 bit 0.
REQ-023 SHIFT_HI -> SHIFT_LO while index < N, else -> FINISH; every sampled bit is followed by exactly one shift pulse.
REQ-024 FINISH lasts one cycle; done = 1 in that cycle; then IDLE.
REQ-025 busy = 1 in every state except IDLE.
REQ-026 Total latency, start-accept to done, N>0: 2*CLK_DIV*(N+1)+1 cycles after the accept edge; N=0: done on the cycle after accept.
REQ-027 Unfilled bits of a partially filled final word, and all higher words, read as 0.
REQ-028 rd_data <= buffer[rd_addr] every cycle, 1-cycle latency, legal at any time; during capture shows the partial contents.
REQ-029 Same-cycle buffer write and read of the same word returns the pre-write value.
REQ-030 num_bits > WORDS*16 clamped; index never wraps beyond word WORDS-1.

Reset
REQ-031 reset in any state: next edge FSM = IDLE, scan_clk = 0, scan_en = 0, busy = 0, done = 0, rd_data = 0, index = 0, all buffer words = 0.
REQ-032 reset mid-capture aborts with no done pulse; start asserted together with reset is ignored.

Verification
REQ-033 CLK_DIV=1, scanner model loaded with 16'hA5C3, start with num_bits=16 -> 1 LOAD_HI pulse, 16 shift pulses, done 35 cycles after accept, word0 = 16'hA5C3, word1 = 0.
REQ-034 num_bits=20, stream 16'h1234 then 4'hB -> word0 = 16'h1234, word1 = 16'h000B, words 2..7 = 0.
REQ-035 num_bits=0 -> done on the cycle after accept, scan_clk never rises, prior buffer contents retained.
REQ-036 num_bits=200 -> exactly 128 shift pulses, all 8 words filled, no write past word 7.
REQ-037 start pulsed again at shift 5 of a 16-bit capture -> ignored, single done, result unchanged; reset at shift 5 -> scan_clk/scan_en/busy 0 next cycle, buffer all 0, no done.
REQ-038 CLK_DIV=4: every scan_clk high and low phase measured at exactly 4 cycles; scan_en stable across each scan_clk rising edge.
